// File: rtl/systolic_result_deskew_if.sv
// Row-stream bus for the result deskew block: skewed lane inputs in,
// aligned rows out through a valid/ready handshake.
interface systolic_result_deskew_if #(
   parameter int WIDTH = 16,
   parameter int N     = 4
);
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [N*WIDTH-1:0] out_data;
   logic               out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_last
   );
endinterface

// File: rtl/systolic_result_deskew.sv
// Re-aligns the skewed output edge of the systolic array into N-wide rows and
// buffers them in a FWFT FIFO with tile framing and sticky error flags.
module systolic_result_deskew #(
   parameter int WIDTH     = 16,
   parameter int N         = 4,
   parameter int DEPTH     = 8,
   parameter int TILE_ROWS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   systolic_result_deskew_if.slave  bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     skew_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

   logic [N-1:0]     av;
   logic [WIDTH-1:0] ad [N];
   logic [N*WIDTH-1:0] ad_row;

   // Lane j gets N-1-j stages so that every lane lines up with lane N-1.
   for (genvar j = 0; j < N; j++) begin : g_lane
      localparam int S = N - 1 - j;
      if (S == 0) begin : g_pass
         assign av[j] = bus.in_valid[j];
         assign ad[j] = bus.in_data[j*WIDTH +: WIDTH];
      end else begin : g_dly
         logic [S-1:0]     v_sr;
         logic [WIDTH-1:0] d_sr [S];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_sr <= '0;
               for (int k = 0; k < S; k++) d_sr[k] <= '0;
            end else if (clear) begin
               v_sr <= '0;
               for (int k = 0; k < S; k++) d_sr[k] <= '0;
            end else begin
               v_sr[0] <= bus.in_valid[j];
               d_sr[0] <= bus.in_data[j*WIDTH +: WIDTH];
               for (int k = 1; k < S; k++) begin
                  v_sr[k] <= v_sr[k-1];
                  d_sr[k] <= d_sr[k-1];
               end
            end
         end
         assign av[j] = v_sr[S-1];
         assign ad[j] = d_sr[S-1];
      end
   end

   always_comb begin
      ad_row = '0;
      for (int j = 0; j < N; j++) ad_row[j*WIDTH +: WIDTH] = ad[j];
   end

   logic [N*WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [TW-1:0]      tile_cnt;
   logic all_v, any_v, full, push, pop, tile_end;

   assign all_v    = &av;
   assign any_v    = |av;
   assign full     = (count == CW'(DEPTH));
   assign push     = all_v && !full;
   assign pop      = bus.out_valid && bus.out_ready;
   assign tile_end = (tile_cnt == TW'(TILE_ROWS - 1));

   // Handshake: a row transfers on any edge where out_valid && out_ready;
   // out_data/out_last hold while out_valid && !out_ready, since pushes
   // never write the slot under rd_ptr while the FIFO is non-empty.
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.out_last  = bus.out_valid && tile_end;

   // Storage is not reset; out_data is masked until a row is present.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= ad_row;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tile_cnt <= '0;
         overflow <= 1'b0;
         skew_err <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tile_cnt <= '0;
         overflow <= 1'b0;
         skew_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            tile_cnt <= tile_end ? '0 : tile_cnt + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
         if (all_v && full)   overflow <= 1'b1;
         if (any_v && !all_v) skew_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_systolic_result_deskew.sv
// Randomized bench for systolic_result_deskew: lane-skewed row stimulus,
// row-level reference model feeding a scoreboard queue, independent monitor.
module tb_systolic_result_deskew;
   localparam int WIDTH = 16, N = 4, DEPTH = 8, TILE_ROWS = 4;
   localparam int RW = N * WIDTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic [$clog2(DEPTH):0] count;
   logic overflow, skew_err;

   systolic_result_deskew_if #(.WIDTH(WIDTH), .N(N)) bus ();

   systolic_result_deskew #(
      .WIDTH(WIDTH), .N(N), .DEPTH(DEPTH), .TILE_ROWS(TILE_ROWS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
      .count(count), .overflow(overflow), .skew_err(skew_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   logic [RW-1:0] exp_q[$];
   int m_occ, m_tile;
   logic m_ovf, m_skew;
   // per-lane history of presented inputs, index = cycles ago
   logic hv [N][N];
   logic [WIDTH-1:0] hd [N][N];
   // rows issued upstream, index = cycles ago; lane j shows row lag[j]
   logic rv_v [N+1];
   logic [RW-1:0] rv_d [N+1];
   int lag [N];

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_occ = 0; m_tile = 0; m_ovf = 1'b0; m_skew = 1'b0;
      for (int j = 0; j < N; j++)
         for (int k = 0; k < N; k++) begin hv[j][k] = 1'b0; hd[j][k] = '0; end
   endtask

   task automatic drv_zero();
      for (int k = 0; k <= N; k++) begin rv_v[k] = 1'b0; rv_d[k] = '0; end
   endtask

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int j = 0; j < N; j++) r[j*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
      return r;
   endfunction

   task automatic step(input logic v, input logic [RW-1:0] row, input logic rdy, input logic clr);
      @(posedge clk); #1;
      if (clear) drv_zero();
      clear = clr;
      bus.out_ready = rdy;
      for (int k = N; k >= 1; k--) begin rv_v[k] = rv_v[k-1]; rv_d[k] = rv_d[k-1]; end
      rv_v[0] = v; rv_d[0] = row;
      for (int j = 0; j < N; j++) begin
         bus.in_valid[j] = rv_v[lag[j]];
         bus.in_data[j*WIDTH +: WIDTH] = rv_d[lag[j]][j*WIDTH +: WIDTH];
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      model_reset();
      drv_zero();
      clear = 1'b0;
      bus.in_valid = '0;
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Reference model: a row is complete when each lane's value from N-1-j
   // cycles ago is valid; FIFO tracked as an occupancy plus expected queue.
   initial begin
      logic all_v, any_v, full;
      logic [RW-1:0] row;
      forever begin
         @(posedge clk);
         if (rst_n) begin
            for (int j = 0; j < N; j++) begin
               for (int k = N - 1; k >= 1; k--) begin hv[j][k] = hv[j][k-1]; hd[j][k] = hd[j][k-1]; end
               hv[j][0] = bus.in_valid[j];
               hd[j][0] = bus.in_data[j*WIDTH +: WIDTH];
            end
            all_v = 1'b1; any_v = 1'b0;
            for (int j = 0; j < N; j++) begin
               all_v = all_v & hv[j][N-1-j];
               any_v = any_v | hv[j][N-1-j];
               row[j*WIDTH +: WIDTH] = hd[j][N-1-j];
            end
            if (clear) begin
               model_reset();
            end else begin
               full = (m_occ == DEPTH);
               if (m_occ != 0 && bus.out_ready) begin
                  m_occ--;
                  m_tile = (m_tile == TILE_ROWS - 1) ? 0 : m_tile + 1;
               end
               if (all_v) begin
                  if (full) m_ovf = 1'b1;
                  else begin exp_q.push_back(row); m_occ++; end
               end else if (any_v) m_skew = 1'b1;
            end
         end
      end
   end

   // Monitor: checks DUT outputs mid-cycle and retires rows on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_count", RW'(count), '0);
            chk("rst_out_valid", RW'(bus.out_valid), '0);
            chk("rst_out_last", RW'(bus.out_last), '0);
            chk("rst_out_data", bus.out_data, '0);
            chk("rst_flags", RW'({overflow, skew_err}), '0);
         end else begin
            chk("count", RW'(count), RW'(m_occ));
            chk("out_valid", RW'(bus.out_valid), RW'(m_occ != 0));
            chk("out_last", RW'(bus.out_last), RW'(m_occ != 0 && m_tile == TILE_ROWS - 1));
            chk("overflow", RW'(overflow), RW'(m_ovf));
            chk("skew_err", RW'(skew_err), RW'(m_skew));
            if (bus.out_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_row: got %h expected no row at %0t", bus.out_data, $time);
               end else begin
                  chk("out_data", bus.out_data, exp_q[0]);
                  if (bus.out_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int sent;
      bus.in_valid = '0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      for (int j = 0; j < N; j++) lag[j] = j;
      drv_zero();
      model_reset();
      #12 rst_n = 1'b1;

      // single row, known lane values
      step(1'b1, 64'h0103_0102_0101_0100, 1'b1, 1'b0);
      repeat (8) step(1'b0, '0, 1'b1, 1'b0);
      chk("single_drained", RW'(count), '0);

      // fill to DEPTH, one extra row overflows, then drain in order
      step(1'b0, '0, 1'b0, 1'b1);
      repeat (9) step(1'b1, rand_row(), 1'b0, 1'b0);
      repeat (N) step(1'b0, '0, 1'b0, 1'b0);
      chk("full_count", RW'(count), RW'(DEPTH));
      chk("full_overflow", RW'(overflow), RW'(1));
      repeat (12) step(1'b0, '0, 1'b1, 1'b0);

      // continuous streaming with ready held high
      step(1'b0, '0, 1'b1, 1'b1);
      repeat (12) step(1'b1, rand_row(), 1'b1, 1'b0);
      repeat (6) step(1'b0, '0, 1'b1, 1'b0);

      // pseudorandom ready over 32 rows
      step(1'b0, '0, 1'b1, 1'b1);
      sent = 0;
      for (int i = 0; i < 1000 && sent < 32; i++) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         if (v) sent++;
         step(v, rand_row(), $urandom_range(0, 3) != 0, 1'b0);
      end
      repeat (16) step(1'b0, '0, 1'b1, 1'b0);

      // lane 2 one cycle late: row dropped, flag sticks, later rows pass
      step(1'b0, '0, 1'b1, 1'b1);
      lag[2] = 3;
      step(1'b1, rand_row(), 1'b1, 1'b0);
      repeat (6) step(1'b0, '0, 1'b1, 1'b0);
      lag[2] = 2;
      repeat (3) step(1'b1, rand_row(), 1'b1, 1'b0);
      repeat (6) step(1'b0, '0, 1'b1, 1'b0);
      chk("skew_sticky", RW'(skew_err), RW'(1));

      // synchronous clear with 5 rows buffered and 2 in flight
      step(1'b0, '0, 1'b1, 1'b1);
      repeat (7) step(1'b1, rand_row(), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("clear_count", RW'(count), '0);
      chk("clear_valid", RW'(bus.out_valid), '0);
      repeat (4) step(1'b1, rand_row(), 1'b1, 1'b0);
      repeat (8) step(1'b0, '0, 1'b1, 1'b0);

      // same scenario with an asynchronous reset pulse
      repeat (7) step(1'b1, rand_row(), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      do_reset();
      step(1'b0, '0, 1'b0, 1'b0);
      chk("reset_count", RW'(count), '0);
      chk("reset_flags", RW'({overflow, skew_err}), '0);
      repeat (4) step(1'b1, rand_row(), 1'b1, 1'b0);
      repeat (8) step(1'b0, '0, 1'b1, 1'b0);
      chk("final_queue_empty", RW'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
